// File: rtl/reg_file_scoreboard_pkg.sv
// Shared definitions for the register file / pending-write scoreboard.
//   DATA_W   register width
//   ADDR_W   register index width (2**ADDR_W entries)
//   CNT_W    pending-write counter width (up to 2**CNT_W-1 writes in flight per register)
//   REG_ZERO index of the hard-wired zero register
package reg_file_scoreboard_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned CNT_W    = 2;
    localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/reg_file_scoreboard_pend_counter.sv
// Pending-write counter for one register.
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset
//   inc_i        an issued instruction targets this register
//   dec_i        write-back retires a write to this register
//   count_o      current pending count
//   underflow_o  retire seen while nothing was pending (count held at zero)
module reg_file_scoreboard_pend_counter #(
    parameter int unsigned CNT_W = reg_file_scoreboard_pkg::CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic             underflow_o
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        // Simultaneous inc and dec cancel out.
        if (inc_i && !dec_i && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end else if (dec_i && !inc_i && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o     = count_q;
    assign underflow_o = dec_i && !inc_i && (count_q == '0);

endmodule

// File: rtl/reg_file_scoreboard.sv
// Register file written by write-back and read by decode, with a per-register
// pending-write scoreboard that stalls decode on unresolved RAW hazards and on
// counter saturation.
//   clk, rst                   clock, synchronous active-high reset
//   regWriteW/WriteRegW/resultW write-back port (always accepted)
//   rsD/rtD -> rd1D/rd2D        combinational reads with write-through bypass
//   issueD/issueWriteD/destD    decode issue and destination marking
//   useRsD/useRtD               which sources the issued instruction reads
//   stallD                      decode must hold; issue is ignored this cycle
//   errUnderflow                sticky: retire seen with zero pending count
module reg_file_scoreboard #(
    parameter int unsigned DATA_W = reg_file_scoreboard_pkg::DATA_W,
    parameter int unsigned ADDR_W = reg_file_scoreboard_pkg::ADDR_W,
    parameter int unsigned CNT_W  = reg_file_scoreboard_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              regWriteW,
    input  logic [ADDR_W-1:0] WriteRegW,
    input  logic [DATA_W-1:0] resultW,
    input  logic [ADDR_W-1:0] rsD,
    input  logic [ADDR_W-1:0] rtD,
    output logic [DATA_W-1:0] rd1D,
    output logic [DATA_W-1:0] rd2D,
    input  logic              issueD,
    input  logic              issueWriteD,
    input  logic [ADDR_W-1:0] destD,
    input  logic              useRsD,
    input  logic              useRtD,
    output logic              stallD,
    output logic              errUnderflow
);

    import reg_file_scoreboard_pkg::*;

    localparam int unsigned NumRegs = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] RZero = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs_q [NumRegs];
    logic [CNT_W-1:0]  pend   [NumRegs];
    logic [NumRegs-1:1] underflow;
    logic issue_write_ok;
    logic rs_hazard, rt_hazard, dest_full;
    logic err_q, err_d;

    // Storage; r0 is never written after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else if (regWriteW && (WriteRegW != RZero)) begin
            regs_q[WriteRegW] <= resultW;
        end
    end

    // Reads with same-cycle write-back bypass.
    always_comb begin
        rd1D = '0;
        rd2D = '0;
        if (rsD != RZero) begin
            rd1D = (regWriteW && (WriteRegW == rsD)) ? resultW : regs_q[rsD];
        end
        if (rtD != RZero) begin
            rd2D = (regWriteW && (WriteRegW == rtD)) ? resultW : regs_q[rtD];
        end
    end

    // A source is only clear early when its last pending write retires now.
    always_comb begin
        rs_hazard = useRsD && (rsD != RZero) && (pend[rsD] != '0) &&
                    !(regWriteW && (WriteRegW == rsD) && (pend[rsD] == CNT_W'(1)));
        rt_hazard = useRtD && (rtD != RZero) && (pend[rtD] != '0) &&
                    !(regWriteW && (WriteRegW == rtD) && (pend[rtD] == CNT_W'(1)));
        dest_full = issueWriteD && (destD != RZero) && (pend[destD] == {CNT_W{1'b1}}) &&
                    !(regWriteW && (WriteRegW == destD));
        stallD         = issueD && (rs_hazard || rt_hazard || dest_full);
        issue_write_ok = issueD && !stallD && issueWriteD;
    end

    assign pend[0] = '0;

    for (genvar r = 1; r < NumRegs; r++) begin : g_pend
        logic inc_r, dec_r;
        assign inc_r = issue_write_ok && (destD == ADDR_W'(r));
        assign dec_r = regWriteW && (WriteRegW == ADDR_W'(r));

        reg_file_scoreboard_pend_counter #(
            .CNT_W (CNT_W)
        ) u_pend_counter (
            .clk_i       (clk),
            .rst_i       (rst),
            .inc_i       (inc_r),
            .dec_i       (dec_r),
            .count_o     (pend[r]),
            .underflow_o (underflow[r])
        );
    end

    assign err_d = err_q || (|underflow);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign errUnderflow = err_q;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
module tb_reg_file_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        regWriteW;
    logic [4:0]  WriteRegW;
    logic [31:0] resultW;
    logic [4:0]  rsD, rtD, destD;
    logic [31:0] rd1D, rd2D;
    logic        issueD, issueWriteD, useRsD, useRtD;
    logic        stallD, errUnderflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_file_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .regWriteW    (regWriteW),
        .WriteRegW    (WriteRegW),
        .resultW      (resultW),
        .rsD          (rsD),
        .rtD          (rtD),
        .rd1D         (rd1D),
        .rd2D         (rd2D),
        .issueD       (issueD),
        .issueWriteD  (issueWriteD),
        .destD        (destD),
        .useRsD       (useRsD),
        .useRtD       (useRtD),
        .stallD       (stallD),
        .errUnderflow (errUnderflow)
    );

    task automatic idle();
        rst = 1'b0; regWriteW = 1'b0; WriteRegW = '0; resultW = '0;
        rsD = '0; rtD = '0; destD = '0;
        issueD = 1'b0; issueWriteD = 1'b0; useRsD = 1'b0; useRtD = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_dest(input logic [4:0] d);
        idle();
        issueD = 1'b1; issueWriteD = 1'b1; destD = d;
        step();
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        step(); step();
        idle();
        rsD = 5'd5; rtD = 5'd9; #1;
        checks++; if (rd1D !== 32'd0) begin errors++; $display("FAIL reset_rd1 got %h want %h", rd1D, 32'd0); end
        checks++; if (rd2D !== 32'd0) begin errors++; $display("FAIL reset_rd2 got %h want %h", rd2D, 32'd0); end
        checks++; if (errUnderflow !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", errUnderflow); end
        issueD = 1'b1; useRsD = 1'b1; useRtD = 1'b1; #1;
        checks++; if (stallD !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stallD); end
        idle();
    endtask

    task automatic test_write_bypass();
        issue_dest(5'd5);
        regWriteW = 1'b1; WriteRegW = 5'd5; resultW = 32'd3; rsD = 5'd5; rtD = 5'd6; #1;
        checks++; if (rd1D !== 32'd3) begin errors++; $display("FAIL bypass_rd1 got %h want %h", rd1D, 32'd3); end
        checks++; if (rd2D !== 32'd0) begin errors++; $display("FAIL bypass_other got %h want %h", rd2D, 32'd0); end
        step(); idle();
        rsD = 5'd5; rtD = 5'd5; #1;
        checks++; if (rd1D !== 32'd3) begin errors++; $display("FAIL array_rd1 got %h want %h", rd1D, 32'd3); end
        checks++; if (rd2D !== 32'd3) begin errors++; $display("FAIL array_rd2 got %h want %h", rd2D, 32'd3); end
        checks++; if (errUnderflow !== 1'b0) begin errors++; $display("FAIL bypass_err got %b want 0", errUnderflow); end
        idle();
    endtask

    task automatic test_raw();
        issue_dest(5'd7);
        issueD = 1'b1; useRsD = 1'b1; rsD = 5'd7; #1;
        checks++; if (stallD !== 1'b1) begin errors++; $display("FAIL raw_rs_stall got %b want 1", stallD); end
        regWriteW = 1'b1; WriteRegW = 5'd7; resultW = 32'd1; #1;
        checks++; if (stallD !== 1'b0) begin errors++; $display("FAIL raw_rs_resolve got %b want 0", stallD); end
        checks++; if (rd1D !== 32'd1) begin errors++; $display("FAIL raw_rs_data got %h want %h", rd1D, 32'd1); end
        step(); idle();
        issue_dest(5'd7);
        issueD = 1'b1; useRtD = 1'b1; rtD = 5'd7; #1;
        checks++; if (stallD !== 1'b1) begin errors++; $display("FAIL raw_rt_stall got %b want 1", stallD); end
        useRtD = 1'b0; #1;
        checks++; if (stallD !== 1'b0) begin errors++; $display("FAIL raw_rt_unused got %b want 0", stallD); end
        idle();
        regWriteW = 1'b1; WriteRegW = 5'd7; resultW = 32'd1;
        step(); idle();
        issueD = 1'b1; useRtD = 1'b1; rtD = 5'd7; #1;
        checks++; if (stallD !== 1'b0) begin errors++; $display("FAIL raw_rt_clear got %b want 0", stallD); end
        checks++; if (rd2D !== 32'd1) begin errors++; $display("FAIL raw_rt_data got %h want %h", rd2D, 32'd1); end
        idle();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 3; i++) begin
            issueD = 1'b1; issueWriteD = 1'b1; destD = 5'd9; #1;
            checks++; if (stallD !== 1'b0) begin errors++; $display("FAIL sat_issue%0d got %b want 0", i, stallD); end
            step(); idle();
        end
        issueD = 1'b1; issueWriteD = 1'b1; destD = 5'd9; #1;
        checks++; if (stallD !== 1'b1) begin errors++; $display("FAIL sat_full got %b want 1", stallD); end
        step(); idle();
        issueD = 1'b1; issueWriteD = 1'b1; destD = 5'd9; #1;
        checks++; if (stallD !== 1'b1) begin errors++; $display("FAIL sat_held got %b want 1", stallD); end
        regWriteW = 1'b1; WriteRegW = 5'd9; #1;
        checks++; if (stallD !== 1'b0) begin errors++; $display("FAIL sat_retire_exempt got %b want 0", stallD); end
        idle();
        regWriteW = 1'b1; WriteRegW = 5'd9; resultW = 32'h99;
        step(); idle();
        issueD = 1'b1; issueWriteD = 1'b1; destD = 5'd9; #1;
        checks++; if (stallD !== 1'b0) begin errors++; $display("FAIL sat_pend2_dest got %b want 0", stallD); end
        idle();
        issueD = 1'b1; useRsD = 1'b1; rsD = 5'd9; regWriteW = 1'b1; WriteRegW = 5'd9; #1;
        checks++; if (stallD !== 1'b1) begin errors++; $display("FAIL sat_pend2_src got %b want 1", stallD); end
        idle();
        issueD = 1'b1; issueWriteD = 1'b1; destD = 5'd9;
        regWriteW = 1'b1; WriteRegW = 5'd9; resultW = 32'h9a; #1;
        checks++; if (stallD !== 1'b0) begin errors++; $display("FAIL sat_same_cycle got %b want 0", stallD); end
        step(); idle();
        issueD = 1'b1; issueWriteD = 1'b1; destD = 5'd9; #1;
        checks++; if (stallD !== 1'b0) begin errors++; $display("FAIL sat_after_same_dest got %b want 0", stallD); end
        idle();
        issueD = 1'b1; useRsD = 1'b1; rsD = 5'd9; regWriteW = 1'b1; WriteRegW = 5'd9; #1;
        checks++; if (stallD !== 1'b1) begin errors++; $display("FAIL sat_after_same_src got %b want 1", stallD); end
        idle();
        regWriteW = 1'b1; WriteRegW = 5'd9; resultW = 32'h9b; step();
        resultW = 32'h9c; step(); idle();
        issueD = 1'b1; useRsD = 1'b1; rsD = 5'd9; #1;
        checks++; if (stallD !== 1'b0) begin errors++; $display("FAIL sat_drained got %b want 0", stallD); end
        checks++; if (rd1D !== 32'h9c) begin errors++; $display("FAIL sat_data got %h want %h", rd1D, 32'h9c); end
        checks++; if (errUnderflow !== 1'b0) begin errors++; $display("FAIL sat_err got %b want 0", errUnderflow); end
        idle();
    endtask

    task automatic test_underflow();
        checks++; if (errUnderflow !== 1'b0) begin errors++; $display("FAIL uf_before got %b want 0", errUnderflow); end
        regWriteW = 1'b1; WriteRegW = 5'd4; resultW = 32'h44;
        step(); idle();
        rsD = 5'd4; #1;
        checks++; if (errUnderflow !== 1'b1) begin errors++; $display("FAIL uf_set got %b want 1", errUnderflow); end
        checks++; if (rd1D !== 32'h44) begin errors++; $display("FAIL uf_data got %h want %h", rd1D, 32'h44); end
        step(); step(); step();
        checks++; if (errUnderflow !== 1'b1) begin errors++; $display("FAIL uf_sticky got %b want 1", errUnderflow); end
        idle();
    endtask

    task automatic test_r0();
        regWriteW = 1'b1; WriteRegW = 5'd0; resultW = 32'hFFFF_FFFF; rsD = 5'd0; rtD = 5'd0; #1;
        checks++; if (rd1D !== 32'd0) begin errors++; $display("FAIL r0_bypass got %h want %h", rd1D, 32'd0); end
        checks++; if (rd2D !== 32'd0) begin errors++; $display("FAIL r0_bypass2 got %h want %h", rd2D, 32'd0); end
        step(); idle();
        rsD = 5'd0; #1;
        checks++; if (rd1D !== 32'd0) begin errors++; $display("FAIL r0_read got %h want %h", rd1D, 32'd0); end
        for (int i = 0; i < 4; i++) issue_dest(5'd0);
        issueD = 1'b1; issueWriteD = 1'b1; destD = 5'd0;
        useRsD = 1'b1; rsD = 5'd0; useRtD = 1'b1; rtD = 5'd0; #1;
        checks++; if (stallD !== 1'b0) begin errors++; $display("FAIL r0_stall got %b want 0", stallD); end
        idle();
    endtask

    task automatic test_reset_all();
        issue_dest(5'd7);
        issue_dest(5'd7);
        issueD = 1'b1; useRsD = 1'b1; rsD = 5'd7; regWriteW = 1'b1; WriteRegW = 5'd7; #1;
        checks++; if (stallD !== 1'b1) begin errors++; $display("FAIL rst_pre_pend2 got %b want 1", stallD); end
        idle();
        rst = 1'b1; regWriteW = 1'b1; WriteRegW = 5'd5; resultW = 32'h77;
        issueD = 1'b1; issueWriteD = 1'b1; destD = 5'd7;
        step(); idle();
        rsD = 5'd5; rtD = 5'd4; #1;
        checks++; if (rd1D !== 32'd0) begin errors++; $display("FAIL rst_r5 got %h want %h", rd1D, 32'd0); end
        checks++; if (rd2D !== 32'd0) begin errors++; $display("FAIL rst_r4 got %h want %h", rd2D, 32'd0); end
        checks++; if (errUnderflow !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", errUnderflow); end
        issueD = 1'b1; useRsD = 1'b1; rsD = 5'd7; #1;
        checks++; if (stallD !== 1'b0) begin errors++; $display("FAIL rst_pend7 got %b want 0", stallD); end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_write_bypass();
        test_raw();
        test_saturation();
        test_underflow();
        test_r0();
        test_reset_all();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
